// File: rtl/fp_unpack_pkg.sv
// fp_unpack_pkg: class bit indices and width helpers shared by the unpacker.
package fp_unpack_pkg;
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUBN = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_QNAN = 4;
  localparam int CLS_SNAN = 5;
  localparam int CLS_W    = 6;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic int xw(input int ew);
    return ew + 2;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero count of a W-bit vector.
module fp_lzc #(
  parameter int W = 23
) (
  input  logic [W-1:0]         d,
  output logic [$clog2(W)-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++)
      if (d[i]) cnt = ($clog2(W))'(W - 1 - i);
  end
endmodule

// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: 2-stage IEEE-754 field unpacker with sNaN/qNaN classes.
// Define FP_UNPACK_NORM_EN to normalise subnormals to a leading-1 significand.
module fp_unpack_pipe
  import fp_unpack_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_sign,
  output logic [xw(EXP_W)-1:0]   out_exp,
  output logic [MAN_W:0]         out_sig,
  output logic [CLS_W-1:0]       out_class,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int XW = xw(EXP_W);
  localparam logic [XW-1:0] B  = XW'(bias(EXP_W));
  localparam logic [XW-1:0] NB = XW'(-bias(EXP_W));
  logic v1, v2, adv1, adv2, s1;
  logic [EXP_W-1:0] e, e1;
  logic [MAN_W-1:0] m, m1;
  logic [CLS_W-1:0] cls, c1;
  logic ez, ea, mz;
  logic [XW-1:0] exp_sub, exp_n;
  logic [MAN_W:0] sig_sub, sig_n;
  assign e = in_data[EXP_W+MAN_W-1 -: EXP_W];
  assign m = in_data[MAN_W-1:0];
  assign ez = ~|e;
  assign ea = &e;
  assign mz = ~|m;
  assign adv2 = !v2 || out_ready;
  assign adv1 = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v2;
  always_comb begin
    cls = '0;
    cls[CLS_ZERO] = ez & mz;
    cls[CLS_SUBN] = ez & !mz;
    cls[CLS_NORM] = !ez & !ea;
    cls[CLS_INF]  = ea & mz;
    cls[CLS_QNAN] = ea & m[MAN_W-1];
    cls[CLS_SNAN] = ea & !mz & !m[MAN_W-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      e1 <= '0;
      m1 <= '0;
      c1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1 <= in_data[EXP_W+MAN_W];
        e1 <= e;
        m1 <= m;
        c1 <= cls;
      end
    end
`ifdef FP_UNPACK_NORM_EN
  localparam int PW = $clog2(MAN_W);
  logic [PW-1:0] p, p1;
  logic [PW:0] sh;
  fp_lzc #(.W(MAN_W)) u_lzc (.d(m), .cnt(p));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p1 <= '0;
    else if (adv1 && in_valid) p1 <= p;
  // Shift by p+1 drops the leading zeros and the zero hidden bit together.
  assign sh = (PW+1)'(p1) + 1'b1;
  assign exp_sub = NB - XW'(p1);
  assign sig_sub = {1'b0, m1} << sh;
`else
  assign exp_sub = NB + 1'b1;
  assign sig_sub = {1'b0, m1};
`endif
  always_comb begin
    exp_n = c1[CLS_NORM] ? {2'b00, e1} - B : c1[CLS_SUBN] ? exp_sub : '0;
    sig_n = c1[CLS_ZERO] ? '0 : c1[CLS_SUBN] ? sig_sub : {1'b1, m1};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= 1'b0;
      out_sign <= 1'b0;
      out_exp <= '0;
      out_sig <= '0;
      out_class <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_sign <= s1;
        out_exp <= exp_n;
        out_sig <= sig_n;
        out_class <= c1;
      end
    end
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb_fp_unpack_pipe: directed vectors, back-pressure stream, reset and half-precision checks.
module tb_fp_unpack_pipe;
  logic clk = 0, rst_n = 0;
  logic [31:0] in_data = '0;
  logic in_valid = 0, in_ready, out_sign, out_valid, out_ready = 1;
  logic [9:0] out_exp;
  logic [23:0] out_sig;
  logic [5:0] out_class;
  logic [15:0] h_data = '0;
  logic h_valid = 0, h_ready, h_sign, h_ovalid;
  logic [6:0] h_exp;
  logic [10:0] h_sig;
  logic [5:0] h_class;
  int checks = 0, errors = 0;
  logic [31:0] tw[8];
  logic ts[8];
  logic [9:0] te[8];
  logic [23:0] tg[8];
  logic [5:0] tc[8];
  always #5 clk = ~clk;
  fp_unpack_pipe dut (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
    .out_class(out_class), .out_valid(out_valid), .out_ready(out_ready));
  fp_unpack_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .in_data(h_data),
    .in_valid(h_valid), .in_ready(h_ready), .out_sign(h_sign), .out_exp(h_exp),
    .out_sig(h_sig), .out_class(h_class), .out_valid(h_ovalid), .out_ready(1'b1));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic one(input int k);
    @(posedge clk); #1;
    in_valid = 1;
    in_data = tw[k];
    check($sformatf("rdy_%0d", k), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    check($sformatf("lat1_%0d", k), out_valid, 0);
    @(posedge clk); #1;
    check($sformatf("lat2_%0d", k), out_valid, 1);
    check($sformatf("sign_%0d", k), out_sign, ts[k]);
    check($sformatf("exp_%0d", k), out_exp, te[k]);
    check($sformatf("sig_%0d", k), out_sig, tg[k]);
    check($sformatf("cls_%0d", k), out_class, tc[k]);
    check($sformatf("onehot_%0d", k), $countones(out_class), 1);
  endtask
  task automatic half(input logic [15:0] w, input logic [6:0] ex, input logic [10:0] sg, input logic [5:0] c);
    @(posedge clk); #1;
    h_valid = 1;
    h_data = w;
    @(posedge clk); #1;
    h_valid = 0;
    @(posedge clk); #1;
    check("h_valid", h_ovalid, 1);
    check("h_exp", h_exp, ex);
    check("h_sig", h_sig, sg);
    check("h_cls", h_class, c);
  endtask
  initial begin
    int sent, rcv, occ;
    logic hv, hs;
    logic [9:0] he;
    logic [23:0] hg;
    logic [5:0] hc;
    tw[0] = 32'h42000000; ts[0] = 0; te[0] = 10'd5;   tg[0] = 24'h800000; tc[0] = 6'b000100;
    tw[1] = 32'he97e1c91; ts[1] = 1; te[1] = 10'd83;  tg[1] = 24'hFE1C91; tc[1] = 6'b000100;
`ifdef FP_UNPACK_NORM_EN
    tw[2] = 32'h0020aac8; ts[2] = 0; te[2] = -10'sd128; tg[2] = 24'h82AB20; tc[2] = 6'b000010;
`else
    tw[2] = 32'h0020aac8; ts[2] = 0; te[2] = -10'sd126; tg[2] = 24'h20AAC8; tc[2] = 6'b000010;
`endif
    tw[3] = 32'h7f800000; ts[3] = 0; te[3] = 10'd0;   tg[3] = 24'h800000; tc[3] = 6'b001000;
    tw[4] = 32'h7fffffff; ts[4] = 0; te[4] = 10'd0;   tg[4] = 24'hFFFFFF; tc[4] = 6'b010000;
    tw[5] = 32'h7f800001; ts[5] = 0; te[5] = 10'd0;   tg[5] = 24'h800001; tc[5] = 6'b100000;
    tw[6] = 32'h80000000; ts[6] = 1; te[6] = 10'd0;   tg[6] = 24'h000000; tc[6] = 6'b000001;
    tw[7] = 32'h3f800000; ts[7] = 0; te[7] = 10'd0;   tg[7] = 24'h800000; tc[7] = 6'b000100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sign", out_sign, 0);
    check("rst_exp", out_exp, 0);
    check("rst_sig", out_sig, 0);
    check("rst_cls", out_class, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) one(k);
    sent = 0; rcv = 0; occ = 0; hv = 0;
    hs = 0; he = '0; hg = '0; hc = '0;
    for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = cyc[0];
      in_valid = (sent < 8) && (cyc % 3 != 2);
      in_data = tw[sent < 8 ? sent : 0];
      @(negedge clk);
      check("bp_ready", in_ready, (occ < 2) || out_ready);
      if (hv) begin
        check("stall_valid", out_valid, 1);
        check("stall_sign", out_sign, hs);
        check("stall_exp", out_exp, he);
        check("stall_sig", out_sig, hg);
        check("stall_cls", out_class, hc);
      end
      hv = out_valid && !out_ready;
      if (hv) begin
        hs = out_sign; he = out_exp; hg = out_sig; hc = out_class;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_sign_%0d", rcv), out_sign, ts[rcv]);
        check($sformatf("bp_exp_%0d", rcv), out_exp, te[rcv]);
        check($sformatf("bp_sig_%0d", rcv), out_sig, tg[rcv]);
        check($sformatf("bp_cls_%0d", rcv), out_class, tc[rcv]);
        rcv++;
      end
      occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (in_valid && in_ready) sent++;
    end
    check("bp_count", rcv, 8);
    @(posedge clk); #1;
    out_ready = 1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1;
    in_data = tw[1];
    @(posedge clk); #1;
    in_data = tw[0];
    @(posedge clk); #1;
    in_valid = 0;
    check("inflight_valid", out_valid, 1);
    rst_n = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sign", out_sign, 0);
    check("mid_rst_exp", out_exp, 0);
    check("mid_rst_sig", out_sig, 0);
    check("mid_rst_cls", out_class, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    one(2);
`ifdef FP_UNPACK_NORM_EN
    half(16'h0001, -7'sd24, 11'h400, 6'b000010);
`else
    half(16'h0001, -7'sd14, 11'h001, 6'b000010);
`endif
    half(16'h3c00, 7'd0, 11'h400, 6'b000100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
